// File: rtl/logic_unit_pkg.sv
// -----------------------------------------------------------------------------
// logic_unit_pkg
// Shared definitions for the registered logic unit: operation encoding and
// the width of the operation-select field.
// -----------------------------------------------------------------------------
package logic_unit_pkg;

   localparam int OP_W = 3;

   typedef enum logic [OP_W-1:0] {
      OP_AND  = 3'd0,
      OP_OR   = 3'd1,
      OP_XOR  = 3'd2,
      OP_NAND = 3'd3,
      OP_NOR  = 3'd4,
      OP_XNOR = 3'd5,
      OP_NOT  = 3'd6,
      OP_RSVD = 3'd7
   } op_e;

endpackage

// File: rtl/logic_unit_core.sv
// -----------------------------------------------------------------------------
// logic_unit_core
// Purely combinational bitwise operation stage.
//   a_i      : operand A (WIDTH)
//   b_i      : operand B (WIDTH), ignored for OP_NOT
//   op_i     : operation select (logic_unit_pkg::op_e encoding)
//   result_o : bitwise result (WIDTH); zero for the reserved opcode
//   err_o    : high when op_i is the reserved opcode
// -----------------------------------------------------------------------------
module logic_unit_core
   import logic_unit_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [OP_W-1:0]  op_i,
   output logic [WIDTH-1:0] result_o,
   output logic             err_o
);

   always_comb begin
      result_o = '0;
      err_o    = 1'b0;
      case (op_e'(op_i))
         OP_AND:  result_o = a_i & b_i;
         OP_OR:   result_o = a_i | b_i;
         OP_XOR:  result_o = a_i ^ b_i;
         OP_NAND: result_o = ~(a_i & b_i);
         OP_NOR:  result_o = ~(a_i | b_i);
         OP_XNOR: result_o = ~(a_i ^ b_i);
         OP_NOT:  result_o = ~a_i;
         default: begin
            result_o = '0;
            err_o    = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/logic_unit_pipe.sv
// -----------------------------------------------------------------------------
// logic_unit_pipe
// Registered bitwise logic unit with valid/ready handshake on both sides,
// optional accumulator feedback, result status flags and a saturating count
// of accepted operand transfers.
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_ready   : operand handshake (in_ready combinational)
//   in_a, in_b, in_op   : operands and operation select
//   in_acc, acc_clr     : use accumulator as operand A / clear accumulator
//   out_valid/out_ready : result handshake
//   out_data            : registered result
//   out_zero/ones/parity: status flags of out_data
//   out_err             : result came from the reserved opcode
//   txn_count           : accepted transfers, saturating at all ones
// -----------------------------------------------------------------------------
module logic_unit_pipe
   import logic_unit_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int ACC_EN = 1,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [OP_W-1:0]  in_op,
   input  logic             in_acc,
   input  logic             acc_clr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_zero,
   output logic             out_ones,
   output logic             out_parity,
   output logic             out_err,
   output logic [CNT_W-1:0] txn_count
);

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q,  out_data_d;
   logic             zero_q,      zero_d;
   logic             ones_q,      ones_d;
   logic             parity_q,    parity_d;
   logic             err_q,       err_d;
   logic [WIDTH-1:0] acc_q,       acc_d;
   logic [CNT_W-1:0] cnt_q,       cnt_d;

   logic             accept;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] core_result;
   logic             core_err;

   // Single output register with no skid buffer: a new operand can only be
   // taken when the slot is empty or is being drained this cycle.
   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;

   // A clear coinciding with an accumulator-sourced accept wins over the
   // stored value, so operand A becomes zero for that transfer.
   always_comb begin
      op_a = in_a;
      if ((ACC_EN != 0) && in_acc) begin
         op_a = acc_clr ? '0 : acc_q;
      end
   end

   logic_unit_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .a_i      (op_a),
      .b_i      (in_b),
      .op_i     (in_op),
      .result_o (core_result),
      .err_o    (core_err)
   );

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      zero_d      = zero_q;
      ones_d      = ones_q;
      parity_d    = parity_q;
      err_d       = err_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;

      if (accept) begin
         out_valid_d = 1'b1;
         out_data_d  = core_result;
         zero_d      = (core_result == '0);
         ones_d      = &core_result;
         parity_d    = ^core_result;
         err_d       = core_err;
         if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end

      // The accumulator tracks every accepted result (reserved op yields 0);
      // a clear only takes effect on its own when nothing is accepted.
      if (ACC_EN == 0) begin
         acc_d = '0;
      end else if (accept) begin
         acc_d = core_result;
      end else if (acc_clr) begin
         acc_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         zero_q      <= 1'b0;
         ones_q      <= 1'b0;
         parity_q    <= 1'b0;
         err_q       <= 1'b0;
         acc_q       <= '0;
         cnt_q       <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         zero_q      <= zero_d;
         ones_q      <= ones_d;
         parity_q    <= parity_d;
         err_q       <= err_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign out_zero   = zero_q;
   assign out_ones   = ones_q;
   assign out_parity = parity_q;
   assign out_err    = err_q;
   assign txn_count  = cnt_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
module tb_logic_unit_pipe;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_a = '0;
   logic [7:0]  in_b = '0;
   logic [2:0]  in_op = '0;
   logic        in_acc = 1'b0;
   logic        acc_clr = 1'b0;
   logic        out_ready = 1'b1;

   logic        in_ready, out_valid, out_zero, out_ones, out_parity, out_err;
   logic [7:0]  out_data;
   logic [15:0] txn_count;

   logic        in_ready2, out_valid2, out_zero2, out_ones2, out_parity2, out_err2;
   logic [7:0]  out_data2;
   logic [2:0]  txn_count2;

   int n_checks = 0;
   int n_errors = 0;

   // Reference state, derived from the behavioural description.
   bit        m_valid;
   bit [7:0]  m_data;
   bit        m_zero, m_ones, m_par, m_err;
   bit [7:0]  m_acc;
   int        m_cnt;

   always #5 clk = ~clk;

   logic_unit_pipe #(.WIDTH(8), .ACC_EN(1), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_acc(in_acc), .acc_clr(acc_clr),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_zero(out_zero), .out_ones(out_ones), .out_parity(out_parity),
      .out_err(out_err), .txn_count(txn_count)
   );

   logic_unit_pipe #(.WIDTH(8), .ACC_EN(1), .CNT_W(3)) dut_sat (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
      .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_acc(in_acc), .acc_clr(acc_clr),
      .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
      .out_zero(out_zero2), .out_ones(out_ones2), .out_parity(out_parity2),
      .out_err(out_err2), .txn_count(txn_count2)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Per-bit truth table lookup, indexed by {a_bit, b_bit}.
   function automatic bit [7:0] ref_op(input bit [7:0] a, input bit [7:0] b, input int op);
      bit [3:0] tt;
      bit [7:0] r;
      case (op)
         0: tt = 4'b1000;
         1: tt = 4'b1110;
         2: tt = 4'b0110;
         3: tt = 4'b0111;
         4: tt = 4'b0001;
         5: tt = 4'b1001;
         6: tt = 4'b0011;
         default: return 8'h00;
      endcase
      for (int i = 0; i < 8; i++) r[i] = tt[{a[i], b[i]}];
      return r;
   endfunction

   function automatic int popcount(input bit [7:0] v);
      int n = 0;
      for (int i = 0; i < 8; i++) n += v[i];
      return n;
   endfunction

   task automatic model_reset();
      m_valid = 0; m_data = 0; m_zero = 0; m_ones = 0; m_par = 0; m_err = 0;
      m_acc = 0; m_cnt = 0;
   endtask

   task automatic check_outputs(input string tag);
      check({tag, ".valid"},  out_valid,  m_valid);
      check({tag, ".data"},   out_data,   m_data);
      check({tag, ".zero"},   out_zero,   m_zero);
      check({tag, ".ones"},   out_ones,   m_ones);
      check({tag, ".parity"}, out_parity, m_par);
      check({tag, ".err"},    out_err,    m_err);
      check({tag, ".count"},  txn_count,  m_cnt);
      check({tag, ".data_s"}, out_data2,  m_data);
      check({tag, ".count_s"}, txn_count2, (m_cnt > 7) ? 7 : m_cnt);
   endtask

   // One clock cycle: drive at the falling edge, check ready, advance the
   // model across the rising edge and check the registered outputs.
   task automatic cycle(input string tag, input bit v, input bit [7:0] a, input bit [7:0] b,
                        input int op, input bit use_acc, input bit clr, input bit ordy);
      bit        rdy, acc_ok;
      bit [7:0]  opa, res;
      @(negedge clk);
      in_valid = v; in_a = a; in_b = b; in_op = op[2:0];
      in_acc = use_acc; acc_clr = clr; out_ready = ordy;
      #1;
      rdy = !m_valid || ordy;
      check({tag, ".in_ready"}, in_ready, rdy);
      check({tag, ".in_ready_s"}, in_ready2, rdy);
      acc_ok = v && rdy;
      if (acc_ok) begin
         opa = use_acc ? (clr ? 8'h00 : m_acc) : a;
         res = ref_op(opa, b, op);
      end else begin
         opa = 8'h00;
         res = 8'h00;
      end
      @(posedge clk);
      #1;
      if (acc_ok) begin
         m_valid = 1;
         m_data  = res;
         m_zero  = (res == 0);
         m_ones  = (res == 8'hFF);
         m_par   = popcount(res) % 2;
         m_err   = (op == 7);
         m_acc   = res;
         if (m_cnt < 65535) m_cnt++;
      end else begin
         if (clr) m_acc = 0;
         if (ordy) m_valid = 0;
      end
      check_outputs(tag);
   endtask

   initial begin
      bit [7:0] sweep_exp [7];
      sweep_exp = '{8'h81, 8'hE7, 8'h66, 8'h7E, 8'h18, 8'h99, 8'h3C};

      // Reset state
      model_reset();
      #1;
      check("rst.in_ready", in_ready, 1'b1);
      check_outputs("rst");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Operation sweep with a free-running consumer
      for (int i = 0; i < 7; i++) begin
         cycle("sweep", 1, 8'hC3, 8'hA5, i, 0, 0, 1);
         check("sweep.const", out_data, sweep_exp[i]);
      end
      check("sweep.count", txn_count, 16'd7);
      cycle("drain", 0, 8'h00, 8'h00, 0, 0, 0, 1);

      // Stall: result must hold while the consumer is blocked
      cycle("stall.acc", 1, 8'hFF, 8'h0F, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         cycle("stall", 1, 8'h12, 8'h34, 1, 0, 0, 0);
         check("stall.hold", out_data, 8'h0F);
         check("stall.rdy", in_ready, 1'b0);
      end
      cycle("stall.rel", 1, 8'h12, 8'h34, 1, 0, 0, 1);
      check("stall.next", out_data, 8'h36);

      // Accumulator chain
      cycle("acc.clr", 1, 8'hAA, 8'h01, 1, 1, 1, 1);
      check("acc.c1", out_data, 8'h01);
      cycle("acc.xor", 1, 8'hAA, 8'h03, 2, 1, 0, 1);
      check("acc.c2", out_data, 8'h02);
      cycle("acc.not", 1, 8'hAA, 8'h55, 6, 1, 0, 1);
      check("acc.c3", out_data, 8'hFD);

      // Flags and reserved opcode
      cycle("flg.xor", 1, 8'h5A, 8'h5A, 2, 0, 0, 1);
      check("flg.zero", out_zero, 1'b1);
      check("flg.par0", out_parity, 1'b0);
      cycle("flg.xnor", 1, 8'h5A, 8'h5A, 5, 0, 0, 1);
      check("flg.ones", out_ones, 1'b1);
      cycle("flg.rsvd", 1, 8'h5A, 8'h0F, 7, 0, 0, 1);
      check("flg.rdata", out_data, 8'h00);
      check("flg.err", out_err, 1'b1);
      cycle("flg.accz", 1, 8'hFF, 8'h00, 1, 1, 0, 1);
      check("flg.acc0", out_data, 8'h00);
      check("flg.err0", out_err, 1'b0);
      cycle("flg.par1", 1, 8'h01, 8'h00, 1, 0, 0, 1);
      check("flg.par1v", out_parity, 1'b1);

      // Standalone accumulator clear without an accept
      cycle("clr.set", 1, 8'h3C, 8'h00, 1, 0, 0, 1);
      cycle("clr.only", 0, 8'h00, 8'h00, 0, 0, 1, 1);
      cycle("clr.use", 1, 8'h00, 8'h00, 1, 1, 0, 1);
      check("clr.acc0", out_data, 8'h00);

      // Randomised traffic
      for (int i = 0; i < 400; i++) begin
         cycle("rand", ($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom),
               int'($urandom_range(0, 7)), ($urandom_range(0, 2) == 0),
               ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0));
      end
      check("sat.count_s", txn_count2, 3'd7);

      // Asynchronous reset while a result is stalled
      cycle("ar.acc", 1, 8'h77, 8'h0F, 1, 0, 0, 0);
      cycle("ar.hold", 0, 8'h00, 8'h00, 0, 0, 0, 0);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("ar.valid", out_valid, 1'b0);
      check("ar.count", txn_count, 16'd0);
      check("ar.rdy", in_ready, 1'b1);
      model_reset();
      check_outputs("ar");
      @(negedge clk);
      rst_n = 1'b1;
      cycle("ar.acc0", 1, 8'hFF, 8'h00, 1, 1, 0, 1);
      check("ar.acc0v", out_data, 8'h00);
      check("ar.cnt1", txn_count, 16'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
